// File: rtl/key_pulse_conditioner.sv
// Pushbutton conditioner: synchronize, debounce and turn a raw active-low
// key into one-cycle enable pulses, with optional auto-repeat while held.
module key_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_n,
  output logic       pulse,
  output logic       pressed,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX) + 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] RELEASED    = 2'd0;
  localparam logic [1:0] PRESS_CHK   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] RELEASE_CHK = 2'd3;

  logic          s1;
  logic          s2;
  logic          key_sync;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_nx;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_nx;
  logic          rep_late;
  logic          rep_late_nx;
  logic          fire;
  logic [RW-1:0] rep_last;

  assign key_sync = s2;
  // first repeat waits the long delay, later ones the short rate
  assign rep_last = rep_late ? RATE_LAST : DLY_LAST;

  // two-flop synchronizer, idles at released (1)
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  // debounce FSM and auto-repeat next-state logic
  always_comb begin
    state_nx    = state;
    db_nx       = db_cnt;
    rep_nx      = rep_cnt;
    rep_late_nx = rep_late;
    fire        = 1'b0;
    unique case (state)
      RELEASED: begin
        if (!key_sync) begin
          state_nx = PRESS_CHK;
          db_nx    = '0;
        end
      end
      PRESS_CHK: begin
        if (key_sync) begin
          state_nx = RELEASED;
        end else if (db_cnt == DB_LAST) begin
          state_nx    = HELD;
          fire        = 1'b1;
          rep_nx      = '0;
          rep_late_nx = 1'b0;
        end else begin
          db_nx = db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (key_sync) begin
          state_nx = RELEASE_CHK;
          db_nx    = '0;
        end else if (REPEAT_EN) begin
          if (rep_cnt == rep_last) begin
            fire        = 1'b1;
            rep_nx      = '0;
            rep_late_nx = 1'b1;
          end else begin
            rep_nx = rep_cnt + 1'b1;
          end
        end
      end
      RELEASE_CHK: begin
        if (!key_sync) begin
          state_nx = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nx = RELEASED;
        end else begin
          db_nx = db_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = RELEASED;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= RELEASED;
      db_cnt      <= '0;
      rep_cnt     <= '0;
      rep_late    <= 1'b0;
      pulse       <= 1'b0;
      pressed     <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state    <= state_nx;
      db_cnt   <= db_nx;
      rep_cnt  <= rep_nx;
      rep_late <= rep_late_nx;
      pulse    <= fire;
      pressed  <= (state_nx == HELD) || (state_nx == RELEASE_CHK);
      if (fire) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule
